// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stalls, redirect flushes, fetch bubbles, memory-wait freezes and halt.
// Optional define HAZARD_STALL_COUNT_EN enables the PC-stall cycle counter behind stall_count.
module hazard_unit #(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [4:0]  decode_rs,
    input  logic [4:0]  decode_rt,
    input  logic        execute_mem_to_reg,
    input  logic [4:0]  execute_reg_wr_addr,
    input  logic        memory_dren,
    input  logic        memory_dwen,
    input  logic        memory_branch_taken,
    input  logic        memory_jump,
    input  logic        write_back_halt,
    output logic        pc_en,
    output logic        fetch_decode_en,
    output logic        decode_execute_en,
    output logic        execute_memory_en,
    output logic        memory_write_back_en,
    output logic        fetch_decode_flush,
    output logic        decode_execute_flush,
    output logic        execute_memory_flush,
    output logic        halted,
    output logic        mem_timeout,
    output logic [31:0] stall_count
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait_cnt;
    logic            r_mem_timeout;
    logic            w_mem_busy;
    logic            w_load_use;
    logic            w_redirect;

    assign w_mem_busy = (memory_dren | memory_dwen) & ~dhit;
    assign w_load_use = execute_mem_to_reg & (execute_reg_wr_addr != 5'd0) &
                        ((execute_reg_wr_addr == decode_rs) | (execute_reg_wr_addr == decode_rt));
    assign w_redirect = memory_branch_taken | memory_jump;

    // Halt is only taken once the memory stage is idle; HALTED is left by reset alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN, MEM_WAIT: begin
                    if (write_back_halt && !w_mem_busy) begin
                        r_state <= HALTED;
                    end else if (w_mem_busy) begin
                        r_state <= MEM_WAIT;
                    end else begin
                        r_state <= RUN;
                    end
                end
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    // Saturating wait-duration counter with sticky timeout flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else if (w_mem_busy) begin
            if (r_wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                r_mem_timeout <= 1'b1;
            end
            if (r_wait_cnt != CW'(WAIT_LIMIT)) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign halted      = (r_state == HALTED);
    assign mem_timeout = r_mem_timeout;

    // Priority-ordered latch control, zero latency from inputs.
    always_comb begin
        pc_en                = 1'b0;
        fetch_decode_en      = 1'b0;
        decode_execute_en    = 1'b0;
        execute_memory_en    = 1'b0;
        memory_write_back_en = 1'b0;
        fetch_decode_flush   = 1'b0;
        decode_execute_flush = 1'b0;
        execute_memory_flush = 1'b0;
        if (r_state != HALTED) begin
            if (w_mem_busy) begin
                pc_en = 1'b0;
            end else if (w_redirect) begin
                pc_en                = 1'b1;
                fetch_decode_en      = 1'b1;
                decode_execute_en    = 1'b1;
                execute_memory_en    = 1'b1;
                memory_write_back_en = 1'b1;
                fetch_decode_flush   = 1'b1;
                decode_execute_flush = 1'b1;
                execute_memory_flush = 1'b1;
            end else if (w_load_use) begin
                decode_execute_en    = 1'b1;
                execute_memory_en    = 1'b1;
                memory_write_back_en = 1'b1;
                decode_execute_flush = 1'b1;
            end else if (!ihit) begin
                fetch_decode_en      = 1'b1;
                decode_execute_en    = 1'b1;
                execute_memory_en    = 1'b1;
                memory_write_back_en = 1'b1;
                fetch_decode_flush   = 1'b1;
            end else begin
                pc_en                = 1'b1;
                fetch_decode_en      = 1'b1;
                decode_execute_en    = 1'b1;
                execute_memory_en    = 1'b1;
                memory_write_back_en = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    // Counts cycles the PC is held outside of HALTED, saturating.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state != HALTED) && !pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`else
    assign stall_count = 32'd0;
`endif

endmodule
